// File: rtl/calc2_pkg.sv
// calc2_pkg: shared types, constants and ALU helper for the CALC2 responder
package calc2_pkg;
  localparam int NUM_PORTS = 4;
  localparam int PW = $clog2(NUM_PORTS);
  typedef logic [0:31] word_t;
  typedef enum logic [0:3] {CMD_NOP = 4'd0, CMD_ADD = 4'd1, CMD_SUB = 4'd2, CMD_SHL = 4'd5, CMD_SHR = 4'd6} cmd_e;
  typedef enum logic [0:1] {RESP_NONE = 2'd0, RESP_OK = 2'd1, RESP_ERR = 2'd2} resp_e;
  typedef enum logic {CAP_IDLE, CAP_OP2} cap_e;
  typedef struct packed {
    logic [0:3] cmd;
    logic [0:1] tag;
    word_t      op1;
    word_t      op2;
  } req_t;
  typedef struct packed {
    resp_e resp;
    word_t data;
  } res_t;
  typedef struct packed {
    logic          vld;
    logic [PW-1:0] port;
    logic [0:1]    tag;
    resp_e         resp;
    word_t         data;
  } pipe_t;
  // cmd stays a raw nibble so undefined encodings fall into the error arm
  function automatic res_t alu(input req_t r);
    logic [32:0] sum;
    sum = {1'b0, r.op1} + {1'b0, r.op2};
    case (r.cmd)
      CMD_ADD: alu = sum[32] ? res_t'{RESP_ERR, '0} : res_t'{RESP_OK, sum[31:0]};
      CMD_SUB: alu = (r.op1 < r.op2) ? res_t'{RESP_ERR, '0} : res_t'{RESP_OK, r.op1 - r.op2};
      CMD_SHL: alu = res_t'{RESP_OK, r.op1 << r.op2[27:31]};
      CMD_SHR: alu = res_t'{RESP_OK, r.op1 >> r.op2[27:31]};
      default: alu = res_t'{RESP_ERR, '0};
    endcase
  endfunction
endpackage

// File: rtl/calc2_if.sv
// calc2_if: four-port CALC2 request/response bundle
interface calc2_if;
  import calc2_pkg::*;
  logic [0:3] req_cmd_in  [NUM_PORTS];
  word_t      req_data_in [NUM_PORTS];
  logic [0:1] req_tag_in  [NUM_PORTS];
  logic [0:1] out_resp    [NUM_PORTS];
  word_t      out_data    [NUM_PORTS];
  logic [0:1] out_tag     [NUM_PORTS];
  logic [0:3] proto_err;
  modport master (
    output req_cmd_in, req_data_in, req_tag_in,
    input  out_resp, out_data, out_tag, proto_err
  );
  modport slave (
    input  req_cmd_in, req_data_in, req_tag_in,
    output out_resp, out_data, out_tag, proto_err
  );
endinterface

// File: rtl/calc2_port_fifo.sv
// calc2_port_fifo: two-cycle request capture feeding a DEPTH-entry request FIFO
module calc2_port_fifo import calc2_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic       c_clk,
  input  logic       reset,
  input  logic [0:3] cmd_i,
  input  word_t      data_i,
  input  logic [0:1] tag_i,
  input  logic       pop_i,
  output logic       valid_o,
  output req_t       head_o,
  output logic       drop_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  cap_e state_q, state_d;
  logic [0:3] cmd_q;
  logic [0:1] tag_q;
  word_t op1_q;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t mem_q [DEPTH];
  logic push, full, do_push, do_pop;
  always_ff @(posedge c_clk or posedge reset)
    if (reset) state_q <= CAP_IDLE;
    else state_q <= state_d;
  always_comb state_d = (state_q == CAP_IDLE && cmd_i != '0) ? CAP_OP2 : CAP_IDLE;
  // full is judged on the pre-edge count, so a same-cycle pop cannot rescue a push
  always_comb begin
    push = state_q == CAP_OP2;
    full = cnt_q == CW'(DEPTH);
    do_push = push && !full;
    do_pop = pop_i && cnt_q != '0;
    drop_o = push && full;
    valid_o = cnt_q != '0;
    head_o = mem_q[rd_q];
    wr_d = do_push ? (wr_q == AW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = do_pop ? (rd_q == AW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge c_clk or posedge reset)
    if (reset) begin
      cmd_q <= '0;
      tag_q <= '0;
      op1_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (state_q == CAP_IDLE) begin
        cmd_q <= cmd_i;
        tag_q <= tag_i;
        op1_q <= data_i;
      end
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge c_clk)
    if (do_push) mem_q[wr_q] <= req_t'{cmd_q, tag_q, op1_q, data_i};
endmodule

// File: rtl/calc2_responder.sv
// calc2_responder: four request FIFOs round-robin onto one pipelined ALU with tagged responses
module calc2_responder import calc2_pkg::*; #(
  parameter int ALU_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic   c_clk,
  input logic   reset,
  calc2_if.slave bus
);
  logic [0:NUM_PORTS-1] valid, pop, drop, err_q, err_d;
  req_t head [NUM_PORTS];
  logic gnt_any, hit;
  logic [PW-1:0] gnt_idx, cand, ptr_q, ptr_d;
  res_t res;
  pipe_t issue, last;
  pipe_t pipe_q [ALU_LAT];
  logic [0:1] resp_q [NUM_PORTS], resp_d [NUM_PORTS];
  word_t data_q [NUM_PORTS], data_d [NUM_PORTS];
  logic [0:1] tag_q [NUM_PORTS], tag_d [NUM_PORTS];
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc2_port_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .c_clk   (c_clk),
      .reset   (reset),
      .cmd_i   (bus.req_cmd_in[p]),
      .data_i  (bus.req_data_in[p]),
      .tag_i   (bus.req_tag_in[p]),
      .pop_i   (pop[p]),
      .valid_o (valid[p]),
      .head_o  (head[p]),
      .drop_o  (drop[p])
    );
    assign bus.out_resp[p] = resp_q[p];
    assign bus.out_data[p] = data_q[p];
    assign bus.out_tag[p] = tag_q[p];
  end
  assign bus.proto_err = err_q;
  // scan from the far end so the candidate closest to the pointer wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    cand = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = ptr_q + PW'(k);
      if (valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    pop = '0;
    pop[gnt_idx] = gnt_any;
    ptr_d = gnt_any ? gnt_idx + 1'b1 : ptr_q;
    res = alu(head[gnt_idx]);
    issue = pipe_t'{gnt_any, gnt_idx, head[gnt_idx].tag, res.resp, res.data};
  end
  always_comb begin
    last = pipe_q[ALU_LAT-1];
    hit = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit = last.vld && last.port == PW'(i);
      resp_d[i] = hit ? last.resp : RESP_NONE;
      data_d[i] = hit ? last.data : '0;
      tag_d[i] = hit ? last.tag : '0;
    end
    err_d = err_q | drop;
  end
  always_ff @(posedge c_clk or posedge reset)
    if (reset) begin
      ptr_q <= '0;
      err_q <= '0;
      for (int i = 0; i < ALU_LAT; i++) pipe_q[i] <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        resp_q[i] <= '0;
        data_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
      pipe_q[0] <= issue;
      for (int i = 1; i < ALU_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      resp_q <= resp_d;
      data_q <= data_d;
      tag_q <= tag_d;
    end
endmodule
